// File: rtl/cep_deserializer_pkg.sv
// rtl/cep_deserializer_pkg.sv - CEP deserializer types; carries the shared CEP defines when the header is not pre-included
`ifndef CEP_DEFINES_VH
`define CEP_DEFINES_VH
`define CEP_WORD_WIDTH 64
`define CEP_DATA_WIDTH 512
`define CEP_LENGTH_HI  29
`define CEP_LENGTH_LO  22
`define CEP_LENGTH     29:22
`define CEP_ST_IDLE    2'd0
`define CEP_ST_BODY    2'd1
`define CEP_ST_FULL    2'd2
`define CEP_ST_DRAIN   2'd3
`endif

package cep_deserializer_pkg;

  // Full width of the header length field.
  localparam int CEP_LEN_W = `CEP_LENGTH_HI - `CEP_LENGTH_LO + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = `CEP_ST_IDLE,
    ST_BODY  = `CEP_ST_BODY,
    ST_FULL  = `CEP_ST_FULL,
    ST_DRAIN = `CEP_ST_DRAIN
  } state_t;

endpackage

// File: rtl/cep_defines.vh
// rtl/cep_defines.vh - shared CEP link widths, header length field and deserializer state codes
`ifndef CEP_DEFINES_VH
`define CEP_DEFINES_VH
`define CEP_WORD_WIDTH 64
`define CEP_DATA_WIDTH 512
`define CEP_LENGTH_HI  29
`define CEP_LENGTH_LO  22
`define CEP_LENGTH     29:22
`define CEP_ST_IDLE    2'd0
`define CEP_ST_BODY    2'd1
`define CEP_ST_FULL    2'd2
`define CEP_ST_DRAIN   2'd3
`endif

// File: rtl/cep_deserializer.sv
// rtl/cep_deserializer.sv - reassembles CEP flits into one package; CEP_DESER_LEN_CHECK_EN enables oversize-length check and drain
module cep_deserializer
  import cep_deserializer_pkg::*;
#(
  parameter int WORD_WIDTH = `CEP_WORD_WIDTH,
  parameter int NUM_WORDS  = `CEP_DATA_WIDTH / `CEP_WORD_WIDTH,
  parameter int CNT_WIDTH  = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flit_val,
  input  logic [WORD_WIDTH-1:0]      flit_data,
  output logic                       flit_rdy,
  output logic                       pkg_val,
  output logic [`CEP_DATA_WIDTH-1:0] pkg_data,
  input  logic                       pkg_rdy,
  output logic                       err_len
);

  state_t                      state_q;
  state_t                      state_d;
  logic [CNT_WIDTH-1:0]        cnt_q;
  logic [CNT_WIDTH-1:0]        len_q;
  logic [`CEP_DATA_WIDTH-1:0]  buf_q;
  logic [CNT_WIDTH-1:0]        hdr_len;
  logic                        flit_acc;

  assign flit_acc = flit_val && flit_rdy;

`ifdef CEP_DESER_LEN_CHECK_EN
  logic [CEP_LEN_W-1:0] hdr_len_full;
  logic                 hdr_over;
  logic [CEP_LEN_W-1:0] drain_q;
  logic                 err_q;

  // Oversize headers clamp to the last word; the excess is dropped after delivery.
  always_comb begin
    hdr_len_full = flit_data[`CEP_LENGTH];
    hdr_over     = hdr_len_full > CEP_LEN_W'(NUM_WORDS - 1);
    hdr_len      = hdr_over ? CNT_WIDTH'(NUM_WORDS - 1) : hdr_len_full[CNT_WIDTH-1:0];
  end

  assign err_len = err_q;
`else
  // Upstream keeps len in range, so only the low counter bits matter.
  always_comb begin
    hdr_len = flit_data[`CEP_LENGTH_LO +: CNT_WIDTH];
  end

  assign err_len = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: header, body words, hold until consumed, optional drain.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (flit_acc) begin
          state_d = (hdr_len == '0) ? ST_FULL : ST_BODY;
        end
      end
      ST_BODY: begin
        if (flit_acc && (cnt_q == len_q)) begin
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (pkg_rdy) begin
`ifdef CEP_DESER_LEN_CHECK_EN
          state_d = (drain_q != '0) ? ST_DRAIN : ST_IDLE;
`else
          state_d = ST_IDLE;
`endif
        end
      end
      ST_DRAIN: begin
`ifdef CEP_DESER_LEN_CHECK_EN
        if (flit_acc && (drain_q == CEP_LEN_W'(1))) begin
          state_d = ST_IDLE;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; package data comes straight from the buffer register.
  always_comb begin
    flit_rdy = (state_q != ST_FULL);
    pkg_val  = (state_q == ST_FULL);
    pkg_data = buf_q;
  end

  // Package buffer, word index and length capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      len_q <= '0;
      buf_q <= '0;
`ifdef CEP_DESER_LEN_CHECK_EN
      drain_q <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (flit_acc) begin
            buf_q <= {{(`CEP_DATA_WIDTH - WORD_WIDTH){1'b0}}, flit_data};
            len_q <= hdr_len;
            cnt_q <= CNT_WIDTH'(1);
`ifdef CEP_DESER_LEN_CHECK_EN
            err_q   <= err_q | hdr_over;
            drain_q <= hdr_over ? (hdr_len_full - CEP_LEN_W'(NUM_WORDS - 1)) : '0;
`endif
          end
        end
        ST_BODY: begin
          if (flit_acc) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
              if (cnt_q == CNT_WIDTH'(i)) begin
                buf_q[i*WORD_WIDTH +: WORD_WIDTH] <= flit_data;
              end
            end
            if (cnt_q != len_q) begin
              cnt_q <= cnt_q + CNT_WIDTH'(1);
            end
          end
        end
`ifdef CEP_DESER_LEN_CHECK_EN
        ST_DRAIN: begin
          if (flit_acc) begin
            drain_q <= drain_q - CEP_LEN_W'(1);
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cep_deserializer.sv
// tb/tb_cep_deserializer.sv - directed vector bench for cep_deserializer
module tb_cep_deserializer;

  logic         clk;
  logic         rst_n;
  logic         flit_val;
  logic [63:0]  flit_data;
  logic         flit_rdy;
  logic         pkg_val;
  logic [511:0] pkg_data;
  logic         pkg_rdy;
  logic         err_len;

  int total;
  int bad;

  cep_deserializer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flit_val  (flit_val),
    .flit_data (flit_data),
    .flit_rdy  (flit_rdy),
    .pkg_val   (pkg_val),
    .pkg_data  (pkg_data),
    .pkg_rdy   (pkg_rdy),
    .err_len   (err_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int           len;
    logic [63:0]  tag;
    logic [63:0]  base;
    bit           gaps;
    logic [511:0] exp;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mk_hdr(input int len, input logic [63:0] tag);
    logic [63:0] h;
    h = tag & ~(64'hFF << 22);
    h = h | (64'(len) << 22);
    return h;
  endfunction

  function automatic logic [511:0] model(input logic [63:0] hdr, input logic [63:0] base, input int len);
    logic [511:0] r;
    int n;
    r = '0;
    r[63:0] = hdr;
    n = (len > 7) ? 7 : len;
    for (int k = 1; k <= n; k++) r[k*64 +: 64] = base + 64'(k);
    return r;
  endfunction

  task automatic push(input logic [63:0] d, input bit gaps);
    int guard;
    if (gaps) begin
      flit_val = 1'b0;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end
    flit_val  = 1'b1;
    flit_data = d;
    guard = 0;
    while (!flit_rdy && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 50) begin
      total++;
      bad++;
      $display("FAIL flit_rdy_timeout: got 0 want 1");
    end
    @(posedge clk); #1;
    flit_val = 1'b0;
  endtask

  task automatic send(input logic [63:0] hdr, input logic [63:0] base, input int nbody, input bit gaps, input string nm);
    push(hdr, gaps);
    for (int k = 1; k <= nbody; k++) begin
      check({nm, "_val_early"}, 512'(pkg_val), 512'(0));
      push(base + 64'(k), gaps);
    end
    check({nm, "_val_rise"}, 512'(pkg_val), 512'(1));
  endtask

  task automatic consume(input logic [511:0] exp, input string nm);
    check({nm, "_data"}, pkg_data, exp);
    check({nm, "_rdy_full"}, 512'(flit_rdy), 512'(0));
    pkg_rdy = 1'b1;
    @(posedge clk); #1;
    pkg_rdy = 1'b0;
    check({nm, "_val_fall"}, 512'(pkg_val), 512'(0));
    check({nm, "_rdy_back"}, 512'(flit_rdy), 512'(1));
  endtask

  initial begin
    logic [63:0]  h;
    logic [511:0] e;
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    flit_val  = 1'b0;
    flit_data = '0;
    pkg_rdy   = 1'b0;

    vecs[0] = '{7, 64'hC0DE_0000_0000_0000, 64'h1111_0000_0000_0000, 1'b0, '0};
    vecs[1] = '{4, 64'hAAAA_0000_0000_00A0, 64'h2222_0000_0000_0000, 1'b0, '0};
    vecs[2] = '{7, 64'hBBBB_0000_0000_00B0, 64'h3333_0000_0000_0000, 1'b0, '0};
    vecs[3] = '{0, 64'hCCCC_0000_0000_00C0, 64'h4444_0000_0000_0000, 1'b0, '0};
    vecs[4] = '{7, 64'hC0DE_0000_0000_0000, 64'h1111_0000_0000_0000, 1'b1, '0};
    vecs[5] = '{1, 64'hDDDD_0000_0000_00D0, 64'h5555_0000_0000_0000, 1'b0, '0};
    vecs[6] = '{6, 64'hEEEE_0000_0000_00E0, 64'h6666_0000_0000_0000, 1'b1, '0};
    for (int i = 0; i < 7; i++)
      vecs[i].exp = model(mk_hdr(vecs[i].len, vecs[i].tag), vecs[i].base, vecs[i].len);

    repeat (3) @(posedge clk);
    #1;
    check("rst_pkg_val", 512'(pkg_val), 512'(0));
    check("rst_flit_rdy", 512'(flit_rdy), 512'(1));
    check("rst_pkg_data", pkg_data, 512'(0));
    check("rst_err_len", 512'(err_len), 512'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      send(mk_hdr(vecs[i].len, vecs[i].tag), vecs[i].base, vecs[i].len, vecs[i].gaps, $sformatf("vec%0d", i));
      consume(vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Stall: consumer holds off while the next header is waiting.
    h = mk_hdr(3, 64'h5A5A_0000_0000_0055);
    e = model(h, 64'h7777_0000_0000_0000, 3);
    send(h, 64'h7777_0000_0000_0000, 3, 1'b0, "stall");
    flit_val  = 1'b1;
    flit_data = mk_hdr(0, 64'h9999_0000_0000_0099);
    for (int c = 0; c < 10; c++) begin
      check("stall_flit_rdy", 512'(flit_rdy), 512'(0));
      check("stall_data", pkg_data, e);
      @(posedge clk); #1;
    end
    pkg_rdy = 1'b1;
    @(posedge clk); #1;
    pkg_rdy = 1'b0;
    check("stall_hs_val", 512'(pkg_val), 512'(0));
    check("stall_hs_rdy", 512'(flit_rdy), 512'(1));
    @(posedge clk); #1;
    flit_val = 1'b0;
    check("stall_next_val", 512'(pkg_val), 512'(1));
    consume(model(mk_hdr(0, 64'h9999_0000_0000_0099), 64'h0, 0), "stall_next");

    // Reset in the middle of a package discards it.
    h = mk_hdr(7, 64'hF00D_0000_0000_0000);
    push(h, 1'b0);
    push(64'h8888_0000_0000_0001, 1'b0);
    push(64'h8888_0000_0000_0002, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_val", 512'(pkg_val), 512'(0));
    check("midrst_data", pkg_data, 512'(0));
    check("midrst_rdy", 512'(flit_rdy), 512'(1));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst_idle_val", 512'(pkg_val), 512'(0));
    send(mk_hdr(vecs[0].len, vecs[0].tag), vecs[0].base, 7, 1'b0, "postrst");
    consume(vecs[0].exp, "postrst");

`ifdef CEP_DESER_LEN_CHECK_EN
    // Oversize length: clamp, flag, drop the three extra flits.
    h = mk_hdr(10, 64'h0BAD_0000_0000_0000);
    send(h, 64'h9000_0000_0000_0000, 7, 1'b0, "over");
    check("over_err", 512'(err_len), 512'(1));
    consume(model(h, 64'h9000_0000_0000_0000, 10), "over");
    for (int k = 8; k <= 10; k++) begin
      push(64'h9000_0000_0000_0000 + 64'(k), 1'b0);
      check("drain_val", 512'(pkg_val), 512'(0));
    end
    h = mk_hdr(1, 64'h600D_0000_0000_0000);
    send(h, 64'hA000_0000_0000_0000, 1, 1'b0, "after_drain");
    consume(model(h, 64'hA000_0000_0000_0000, 1), "after_drain");
    check("err_sticky", 512'(err_len), 512'(1));
    rst_n = 1'b0;
    #1;
    check("err_cleared", 512'(err_len), 512'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
`else
    check("err_tied", 512'(err_len), 512'(0));
`endif

    @(posedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
